// File: rtl/rotate_pkg.sv
// Shared types and widths for the rotate arbiter datapath.
package rotate_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned AMT_W  = 3;

    typedef logic src_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [AMT_W-1:0]  amt;
    } rot_req_t;

    typedef enum logic {StEmpty, StFull} out_state_t;

endpackage

// File: rtl/barrel_shifter.sv
// Combinational 8-bit right rotate.
module barrel_shifter
    import rotate_pkg::*;
(
    input  rot_req_t          req,
    output logic [DATA_W-1:0] result
);

    logic [2*DATA_W-1:0] doubled;
    logic [2*DATA_W-1:0] shifted;

    // Rotating the doubled word right leaves the wrapped bits in the low half.
    always_comb begin
        doubled = {req.data, req.data};
        shifted = doubled >> req.amt;
        result  = shifted[DATA_W-1:0];
    end

endmodule

// File: rtl/rotate_arbiter.sv
// Round-robin arbiter sharing one barrel shifter between two requesters,
// with a one-entry registered output stage and saturating grant counters.
module rotate_arbiter
    import rotate_pkg::*;
#(
    parameter src_t        PRIO_RESET = 1'b0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    input  logic [AMT_W-1:0]  req0_amt,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    input  logic [AMT_W-1:0]  req1_amt,
    output logic              req1_ready,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output src_t              res_src,
    input  logic              res_ready,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  gnt_cnt0,
    output logic [CNT_W-1:0]  gnt_cnt1
);

    out_state_t        state_q;
    logic [DATA_W-1:0] res_data_q;
    src_t              res_src_q;
    src_t              last_q;
    logic [CNT_W-1:0]  cnt0_q;
    logic [CNT_W-1:0]  cnt1_q;

    logic              can_load;
    logic              gnt_valid;
    src_t              gnt_idx;
    logic              xfer;
    logic              pop;
    rot_req_t          gnt_req;
    logic [DATA_W-1:0] rot_result;

    always_comb begin
        can_load = (state_q == StEmpty) || res_ready;
        pop      = (state_q == StFull) && res_ready;

        gnt_valid = req0_valid || req1_valid;
        if (req0_valid && req1_valid) begin
            gnt_idx = ~last_q;
        end else if (req1_valid) begin
            gnt_idx = 1'b1;
        end else begin
            gnt_idx = 1'b0;
        end

        // Nothing may transfer while reset is held.
        xfer       = gnt_valid && can_load && !rst;
        req0_ready = xfer && (gnt_idx == 1'b0);
        req1_ready = xfer && (gnt_idx == 1'b1);

        gnt_req = (gnt_idx == 1'b1) ? '{data: req1_data, amt: req1_amt}
                                    : '{data: req0_data, amt: req0_amt};
    end

    barrel_shifter u_barrel_shifter (
        .req    (gnt_req),
        .result (rot_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StEmpty;
            res_data_q <= '0;
            res_src_q  <= 1'b0;
            last_q     <= ~PRIO_RESET;
            cnt0_q     <= '0;
            cnt1_q     <= '0;
        end else begin
            if (xfer) begin
                state_q    <= StFull;
                res_data_q <= rot_result;
                res_src_q  <= gnt_idx;
                last_q     <= gnt_idx;
            end else if (pop) begin
                state_q <= StEmpty;
            end

            if (cnt_clr) begin
                cnt0_q <= '0;
                cnt1_q <= '0;
            end else if (xfer) begin
                if (gnt_idx == 1'b0 && cnt0_q != '1) cnt0_q <= cnt0_q + 1'b1;
                if (gnt_idx == 1'b1 && cnt1_q != '1) cnt1_q <= cnt1_q + 1'b1;
            end
        end
    end

    assign res_valid = (state_q == StFull);
    assign res_data  = res_data_q;
    assign res_src   = res_src_q;
    assign gnt_cnt0  = cnt0_q;
    assign gnt_cnt1  = cnt1_q;

endmodule

// File: doc/rotate_arbiter.md
# rotate_arbiter

Shares one 8-bit right-rotate datapath (`barrel_shifter`) between two independent requesters. Each requester presents an operand and a rotate amount with a valid/ready handshake. The block grants one requester per cycle by round-robin and registers the rotated result in a one-entry output stage with its own valid/ready handshake. It also keeps per-requester saturating grant counters for fairness checks and performance monitoring.

## Interface
- `PRIO_RESET`, default 0: requester that wins the first contended grant after reset (0 or 1).
- `CNT_W`, default 16: width of each grant counter.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has a request.
- `req0_data`  in  8  requester 0 operand.
- `req0_amt`  in  3  requester 0 right-rotate amount.
- `req0_ready`  out  1  requester 0 request accepted this cycle.
- `req1_valid`, `req1_data`, `req1_amt`, `req1_ready`: same as requester 0, for requester 1.
- `res_valid`  out  1  result register holds a valid result.
- `res_data`  out  8  rotated result.
- `res_src`  out  1  index of the requester that produced `res_data`.
- `res_ready`  in  1  consumer accepts the result.
- `cnt_clr`  in  1  synchronous clear of both grant counters.
- `gnt_cnt0`, `gnt_cnt1`  out  CNT_W  saturating accepted-request counts.

## Operation
- Handshake rules:
  - A request transfers when `reqN_valid && reqN_ready`.
  - A result transfers when `res_valid && res_ready`.
  - `reqN_valid`/`data`/`amt` must hold stable until accepted.
  - `reqN_ready` may depend combinationally on `req*_valid` and `res_ready`.
  - `res_valid` never depends combinationally on `res_ready`.
- Output stage has two states:
  - EMPTY (`res_valid`=0).
  - FULL (`res_valid`=1).
  - `can_load` = EMPTY, or FULL with `res_ready`=1 (pop and load in the same cycle).
- Arbitration:
  - Pointer `last` holds the index of the most recently granted requester.
  - Only one valid requester: it is granted.
  - Both valid: grant `~last`.
  - Neither valid: no grant.
  - `reqN_ready` = granted(N) && `can_load`. At most one ready is high per cycle.
  - `last` updates only on an actual transfer, never on a grant blocked by a full output.
- Datapath:
  - Granted operand and amount drive `barrel_shifter` combinationally.
  - On transfer, `res_data` <= rotate-right(data, amt) and `res_src` <= N.
  - amt=0 passes the operand unchanged. Rotation wraps: bit k moves to bit (k−amt) mod 8.
- Output state transitions:
  - EMPTY + transfer -> FULL.
  - FULL + pop, no transfer -> EMPTY.
  - FULL + pop + transfer -> FULL with new data.
  - FULL, no pop -> hold; `res_data`/`res_src` stable.
- Counters:
  - `gnt_cntN` increments on each requester-N transfer and saturates at all-ones.
  - `cnt_clr` forces both counters to 0 and has priority over a same-cycle increment.

## Timing
- Reset values:
  - `res_valid`=0, `res_data`=0, `res_src`=0.
  - `gnt_cnt0`=`gnt_cnt1`=0.
  - `last`=~PRIO_RESET.
  - `req*_ready` low while `rst`=1.
- Latency: request transfer in cycle T -> `res_valid`=1 with the result in cycle T+1.
- Throughput: one result per cycle while `res_ready` is held high; no bubble on simultaneous pop and load.
- Back-pressure: with FULL and `res_ready`=0, both `req*_ready`=0.
- Fairness: with both requesters continuously valid and no stall, grants alternate strictly 0,1,0,1… (starting with PRIO_RESET).
- Reset mid-operation:
  - A held result is discarded and the stage returns to EMPTY.
  - Counters and pointer return to reset values.
  - No transfer is recognised in the reset cycle.

## Structure
- Shared package `rotate_pkg`:
  - `DATA_W`=8, `AMT_W`=3.
  - Requester-index type `src_t` (1 bit).
  - Typedef `rot_req_t` {data, amt}.
- One sub-module: `barrel_shifter` (8-bit right rotate), instantiated once, purely combinational.
- Arbiter pointer, output register and counters stay in the top module.

## Test plan
- Single request: after reset, req0 data=0x96 amt=3 -> `req0_ready`=1 same cycle; next cycle `res_valid`=1, `res_data`=0xD2, `res_src`=0, `gnt_cnt0`=1.
- Contention after reset (PRIO_RESET=0):
  - Both requesters valid continuously (req0 0x81 amt 1, req1 0x0F amt 4), `res_ready`=1.
  - Results alternate 0xC0 (src 0), 0xF0 (src 1), …, one per cycle.
- Back-pressure:
  - FULL and `res_ready`=0 for 3 cycles -> both readys 0; `res_data`/`res_src` unchanged.
  - Raising `res_ready` -> pop and new load in the same cycle.
- amt=0 and amt=7: 0xA5 -> 0xA5; 0x01 amt 7 -> 0x02.
- Counters:
  - Force `gnt_cnt1` to 0xFFFF and issue a req1 transfer -> stays 0xFFFF.
  - `cnt_clr` asserted together with a transfer -> counter reads 0.
- Reset mid-operation: assert `rst` while FULL with `res_ready`=0 -> next cycle `res_valid`=0 and counters 0; first contended grant goes to PRIO_RESET.
